// File: rtl/slow_clk_monitor_pkg.sv
// Shared types for the slow clock monitor: FSM state encodings and small sizing helpers.
// The top and its level filter both import this package.
package slow_clk_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    STALLED   = 2'd2
  } mon_state_e;

  // Width needed to count 0 .. filter-1 stable samples; never narrower than one bit.
  function automatic int unsigned run_cnt_width(input int unsigned filter);
    return (filter > 1) ? $clog2(filter) : 1;
  endfunction

endpackage

// File: rtl/slow_clk_monitor_level_filter.sv
// Synchroniser chain plus stability filter for the slow input.
// Edge strobes are combinational so the top can register them straight into the pulse outputs.
module level_filter
  import slow_clk_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic slow_in,
  output logic level,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned RUN_W = run_cnt_width(FILTER);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [RUN_W-1:0]       run_cnt;
  logic                   synced;
  logic                   differs;
  logic                   accept;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign differs = (synced != level);
  // The FILTER-th consecutive differing sample is accepted on this edge.
  assign accept  = en && differs && (run_cnt == RUN_LAST);

  assign rise_stb = accept && synced;
  assign fall_stb = accept && !synced;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= 1'b0;
      run_cnt <= '0;
    end else if (!en) begin
      // Track the input silently while disabled so re-enabling produces no stale edge.
      level   <= synced;
      run_cnt <= '0;
    end else if (!differs) begin
      run_cnt <= '0;
    end else if (accept) begin
      level   <= synced;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow clock monitor: turns a filtered slow square wave into rise/fall enables,
// measures the half-period in clk cycles and flags a stalled source.
//
// state     | meaning
// WAIT_EDGE | no edge seen since reset/enable; counter runs toward timeout
// MEASURE   | edges arriving; each edge loads half_period and sets period_valid
// STALLED   | TIMEOUT cycles without an edge; next edge re-enters MEASURE unmeasured
module slow_clk_monitor
  import slow_clk_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER      = 4,
  parameter int unsigned TIMEOUT     = 100_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             slow_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

  logic             level;
  logic             rise_stb;
  logic             fall_stb;
  logic             edge_stb;

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_d;
  logic             pv_d;
  logic             rise_d;
  logic             fall_d;

  level_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER      (FILTER)
  ) u_level_filter (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .slow_in  (slow_in),
    .level    (level),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign edge_stb = rise_stb | fall_stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_EDGE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = half_period;
    pv_d    = period_valid;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!en) begin
      state_d = WAIT_EDGE;
      cnt_d   = '0;
      pv_d    = 1'b0;
    end else begin
      rise_d = rise_stb;
      fall_d = fall_stb;
      cnt_d  = (cnt_q >= TO_VAL) ? TO_VAL : cnt_q + CNT_W'(1);
      if (edge_stb) begin
        // Counter is 0 in the pulse cycle, so the distance to this pulse is cnt_q + 1.
        cnt_d = '0;
        case (state_q)
          WAIT_EDGE: state_d = MEASURE;
          MEASURE: begin
            hp_d = cnt_q + CNT_W'(1);
            pv_d = 1'b1;
          end
          STALLED: begin
            state_d = MEASURE;
            pv_d    = 1'b0;
          end
          default: state_d = WAIT_EDGE;
        endcase
      end else if (cnt_q >= TO_M1) begin
        // Decided one cycle early so stalled rises in the cycle the counter reads TIMEOUT.
        state_d = STALLED;
        pv_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
    end else begin
      rise_pulse   <= rise_d;
      fall_pulse   <= fall_d;
      half_period  <= hp_d;
      period_valid <= pv_d;
    end
  end

  assign stalled = (state_q == STALLED);

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Scenario bench for slow_clk_monitor: pulses expected by the stimulus are queued with
// their due cycle and compared by a negedge monitor; scenario tasks check levels inline.
module tb_slow_clk_monitor;
  import slow_clk_monitor_pkg::*;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        slow_in = 1'b0;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [15:0] half_period;
  logic        period_valid;
  logic        stalled;

  typedef struct {
    int          cyc;
    logic        rise;
    logic        fall;
    logic        chk;
    logic [15:0] hp;
    logic        pv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_pulse = 0;

  slow_clk_monitor #(
    .SYNC_STAGES (2),
    .FILTER      (4),
    .TIMEOUT     (1000),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .slow_in      (slow_in),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .half_period  (half_period),
    .period_valid (period_valid),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if ({rise_pulse, fall_pulse} !== {mon_e.rise, mon_e.fall}) begin
        errors++;
        $display("FAIL pulse cyc=%0d got rise/fall=%b%b expected %b%b",
                 cyc, rise_pulse, fall_pulse, mon_e.rise, mon_e.fall);
      end
      if (mon_e.chk) begin
        checks++;
        if (half_period !== mon_e.hp || period_valid !== mon_e.pv || stalled !== 1'b0) begin
          errors++;
          $display("FAIL pulse_meas cyc=%0d got hp=%0d pv=%b st=%b expected hp=%0d pv=%b st=0",
                   cyc, half_period, period_valid, stalled, mon_e.hp, mon_e.pv);
        end
      end
    end else if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
      errors++;
      $display("FAIL unexpected_pulse cyc=%0d got rise/fall=%b%b expected 00",
               cyc, rise_pulse, fall_pulse);
    end
  end

  // Toggle slow_in n times, half cycles apart, queueing the pulse each toggle must produce.
  task automatic run_wave(input int n, input int half, input logic [15:0] hp_first);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      slow_in = ~slow_in;
      e.cyc  = cyc + LAT;
      e.rise = slow_in;
      e.fall = ~slow_in;
      e.chk  = 1'b1;
      e.hp   = (j == 0) ? hp_first : 16'(half);
      e.pv   = (j != 0);
      sb.push_back(e);
      last_pulse = e.cyc;
      repeat (half - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rise_pulse, fall_pulse, half_period, period_valid, stalled} !== 20'd0) begin
        errors++;
        $display("FAIL reset_hold i=%0d got r=%b f=%b hp=%0d pv=%b st=%b expected all 0",
                 i, rise_pulse, fall_pulse, half_period, period_valid, stalled);
      end
      slow_in = ~slow_in;
    end
    @(negedge clk);
    rst = 1'b0;
    slow_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({rise_pulse, fall_pulse, half_period, period_valid, stalled} !== 20'd0) begin
        errors++;
        $display("FAIL reset_release i=%0d got r=%b f=%b hp=%0d pv=%b st=%b expected all 0",
                 i, rise_pulse, fall_pulse, half_period, period_valid, stalled);
      end
    end
  endtask

  task automatic test_square();
    run_wave(6, 50, 16'd0);
  endtask

  task automatic test_glitch();
    exp_t e;
    @(negedge clk);
    slow_in = 1'b1;
    repeat (3) @(negedge clk);
    slow_in = 1'b0;
    repeat (12) @(negedge clk);
    slow_in = 1'b1;
    e.cyc = cyc + LAT; e.rise = 1'b1; e.fall = 1'b0; e.chk = 1'b0; e.hp = 16'd0; e.pv = 1'b1;
    sb.push_back(e);
    repeat (4) @(negedge clk);
    slow_in = 1'b0;
    e.cyc = cyc + LAT; e.rise = 1'b0; e.fall = 1'b1; e.chk = 1'b1; e.hp = 16'd4; e.pv = 1'b1;
    sb.push_back(e);
    last_pulse = e.cyc;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_stall();
    repeat (last_pulse + 999 - cyc) @(negedge clk);
    checks++;
    if (stalled !== 1'b0 || period_valid !== 1'b1 || half_period !== 16'd4) begin
      errors++;
      $display("FAIL stall_before got st=%b pv=%b hp=%0d expected st=0 pv=1 hp=4",
               stalled, period_valid, half_period);
    end
    @(negedge clk);
    checks++;
    if (stalled !== 1'b1 || period_valid !== 1'b0 || half_period !== 16'd4) begin
      errors++;
      $display("FAIL stall_at_timeout got st=%b pv=%b hp=%0d expected st=1 pv=0 hp=4",
               stalled, period_valid, half_period);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (stalled !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold got st=%b expected 1", stalled);
    end
    run_wave(3, 30, 16'd4);
    checks++;
    if (stalled !== 1'b0 || period_valid !== 1'b1 || half_period !== 16'd30) begin
      errors++;
      $display("FAIL stall_resume got st=%b pv=%b hp=%0d expected st=0 pv=1 hp=30",
               stalled, period_valid, half_period);
    end
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (20) begin
        @(negedge clk);
        if (period_valid !== 1'b0 || stalled !== 1'b0 || half_period !== 16'd30) bad++;
      end
      slow_in = ~slow_in;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL en_low_outputs got %0d bad cycles (last pv=%b st=%b hp=%0d) expected 0",
               bad, period_valid, stalled, half_period);
    end
    en = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (period_valid !== 1'b0 || half_period !== 16'd30) begin
      errors++;
      $display("FAIL en_rise_hold got pv=%b hp=%0d expected pv=0 hp=30",
               period_valid, half_period);
    end
    run_wave(3, 40, 16'd30);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rst = 1'b1;
    slow_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({rise_pulse, fall_pulse, half_period, period_valid, stalled} !== 20'd0 ||
        dut.state_q !== WAIT_EDGE) begin
      errors++;
      $display("FAIL mid_reset got r=%b f=%b hp=%0d pv=%b st=%b state=%0d expected all 0, WAIT_EDGE",
               rise_pulse, fall_pulse, half_period, period_valid, stalled, dut.state_q);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_wave(2, 25, 16'd0);
  endtask

  initial begin
    test_reset();
    test_square();
    test_glitch();
    test_stall();
    test_enable();
    test_mid_reset();
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
